// File: rtl/icache_refill.sv
// ---------------------------------------------------------------------------
// icache_refill
//   Refills one 32-bit instruction word into the instruction cache from a
//   16-bit external memory. It reads two halfwords, low address first, then
//   pulses fetch for one cycle with the assembled word.
//
// Ports
//   CLK         clock, rising edge
//   resetn      synchronous, active-low reset
//   cache_miss  miss indication from the instruction cache
//   miss_addr   byte address of the missing instruction (word aligned)
//   fetch       one-cycle pulse: write_data is valid, write it into the cache
//   write_data  refilled instruction word {hi, lo}
//   mem_req     halfword read request to external memory
//   mem_addr    byte address of the requested halfword
//   mem_ack     memory accepted the request; mem_rdata is valid this cycle
//   mem_rdata   halfword read data
//   busy        high in every state except IDLE
//
// Configuration
//   ICACHE_REFILL_LASTBUF_EN  adds a one-entry last-refill buffer. A miss on
//                             the most recently refilled word goes straight to
//                             DONE and is served without touching memory.
// ---------------------------------------------------------------------------
module icache_refill (
    input  logic        CLK,
    input  logic        resetn,
    input  logic        cache_miss,
    input  logic [19:0] miss_addr,
    output logic        fetch,
    output logic [31:0] write_data,
    output logic        mem_req,
    output logic [19:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        DONE  = 3'd3,
        HOLD  = 3'd4
    } state_t;

    localparam logic [19:0] WORD_MASK = 20'hFFFFC;
    localparam logic [19:0] HI_OFFS   = 20'h00002;

    state_t      state;
    logic [19:0] addr_q;
    logic [15:0] lo_q;
    logic [15:0] hi_q;

`ifdef ICACHE_REFILL_LASTBUF_EN
    logic        lb_vld;
    logic [17:0] lb_addr;
    logic [31:0] lb_data;
    logic        lb_hit;

    assign lb_hit = lb_vld && (lb_addr == miss_addr[19:2]);
`endif

    // The assembled word is always visible; fetch alone qualifies it.
    assign write_data = {hi_q, lo_q};

    // Outputs are registered from the next state, so they line up with the
    // state they belong to in the same cycle.
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state    <= IDLE;
            fetch    <= 1'b0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            busy     <= 1'b0;
            addr_q   <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
`ifdef ICACHE_REFILL_LASTBUF_EN
            lb_vld   <= 1'b0;
`endif
        end else begin
            fetch <= 1'b0;
            case (state)
                IDLE: begin
                    if (cache_miss) begin
                        // The address is latched here; later changes on
                        // miss_addr cannot affect this refill.
                        addr_q <= miss_addr & WORD_MASK;
                        busy   <= 1'b1;
`ifdef ICACHE_REFILL_LASTBUF_EN
                        if (lb_hit) begin
                            lo_q  <= lb_data[15:0];
                            hi_q  <= lb_data[31:16];
                            fetch <= 1'b1;
                            state <= DONE;
                        end else
`endif
                        begin
                            mem_req  <= 1'b1;
                            mem_addr <= miss_addr & WORD_MASK;
                            state    <= RD_LO;
                        end
                    end
                end
                RD_LO: begin
                    if (mem_ack) begin
                        lo_q     <= mem_rdata;
                        mem_addr <= addr_q | HI_OFFS;
                        state    <= RD_HI;
                    end
                end
                RD_HI: begin
                    if (mem_ack) begin
                        hi_q    <= mem_rdata;
                        mem_req <= 1'b0;
                        fetch   <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
`ifdef ICACHE_REFILL_LASTBUF_EN
                    lb_vld  <= 1'b1;
                    lb_addr <= addr_q[19:2];
                    lb_data <= {hi_q, lo_q};
`endif
                    state <= HOLD;
                end
                // One dead cycle: a miss seen now is the cache reading the
                // line being written and is stale.
                HOLD: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    mem_req  <= 1'b0;
                    mem_addr <= '0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/icache_refill.md
ICACHE_REFILL -- requirements
Module: icache_refill

Interface
REQ-001 SHALL have port CLK, input, 1, clock; all state changes on its rising edge.
REQ-002 SHALL have port resetn, input, 1, reset; synchronous, active-low.
REQ-003 SHALL have port cache_miss, input, 1, miss indication from instruction cache.
REQ-004 SHALL have port miss_addr, input, 20, byte address of missing instruction, word aligned.
REQ-005 SHALL have port fetch, output, 1, one-cycle pulse: write_data valid, write into cache.
REQ-006 SHALL have port write_data, output, 32, refilled instruction word.
REQ-007 SHALL have port mem_req, output, 1, halfword read request to external 16-bit memory.
REQ-008 SHALL have port mem_addr, output, 20, byte address of requested halfword.
REQ-009 SHALL have port mem_ack, input, 1, memory accepted request; mem_rdata valid this cycle.
REQ-010 SHALL have port mem_rdata, input, 16, halfword read data.
REQ-011 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-012 SHALL implement states IDLE, RD_LO, RD_HI, DONE, HOLD.
REQ-013 IDLE: cache_miss=1 SHALL latch miss_addr into addr_q and go to RD_LO; else stay.
REQ-014 RD_LO SHALL drive mem_req=1, mem_addr={addr_q[19:2],2'b00}; on mem_ack latch mem_rdata into lo_q, go to RD_HI.
REQ-015 RD_HI SHALL drive mem_req=1, mem_addr={addr_q[19:2],2'b10}; on mem_ack latch mem_rdata into hi_q, go to DONE.
REQ-016 mem_req SHALL stay high with stable mem_addr until mem_ack; mem_ack while mem_req=0 SHALL be ignored.
REQ-017 DONE SHALL drive fetch=1 for exactly one cycle, write_data={hi_q,lo_q} (little-endian), then go to HOLD.
REQ-018 HOLD SHALL last exactly one cycle, ignore cache_miss (masks stale read-during-write miss), then go to IDLE.
REQ-019 write_data SHALL hold {hi_q,lo_q} in all states; only qualified by fetch.
REQ-020 Latency, no wait states: cache_miss sampled at edge N -> fetch high in cycle N+3 (ack in RD_LO and RD_HI same cycle as req).
REQ-021 miss_addr changes after latch SHALL NOT affect the refill in progress.
REQ-022 cache_miss in RD_LO/RD_HI/DONE/HOLD SHALL be ignored; new refill only from IDLE.
REQ-023 Unused state encodings SHALL return to IDLE next cycle with all outputs deasserted.

Reset
REQ-024 resetn=0 at edge SHALL force IDLE; fetch=0, mem_req=0, mem_addr=0, busy=0, write_data=0, addr_q/lo_q/hi_q=0.
REQ-025 Reset mid-refill SHALL drop mem_req next cycle and discard partial data; no fetch pulse issued; external memory tolerates abandoned request.

Configuration
REQ-026 Macro ICACHE_REFILL_LASTBUF_EN SHALL enable a one-entry last-refill buffer (valid bit, 18-bit word address, 32-bit data).
REQ-027 With macro: each DONE SHALL write buffer; IDLE miss with buffer valid and miss_addr[19:2] equal SHALL go directly to DONE, fetch with buffered data two cycles earlier, no mem_req.
REQ-028 With macro: reset SHALL clear buffer valid bit.
REQ-029 Without macro: no buffer logic; every miss performs both memory reads.

Verification
REQ-030 Reset, then miss_addr=0x00104, cache_miss=1 one cycle, mem_ack same cycle as each req, mem_rdata 0x0093 then 0x0010 -> mem_addr 0x00104 then 0x00106, fetch one cycle, write_data=0x00100093.
REQ-031 mem_ack delayed 5 cycles per halfword -> mem_req and mem_addr stable throughout, fetch exactly once, busy high from cycle after miss until HOLD exit.
REQ-032 cache_miss held high continuously for 20 cycles, addr 0x00200 -> refills repeat only after HOLD, never overlapping; fetch never on consecutive cycles.
REQ-033 resetn=0 during RD_HI -> mem_req=0 next cycle, no fetch, busy=0; subsequent miss at 0x00008 completes with correct data.
REQ-034 miss_addr changed to 0x3FFFC during RD_LO after latching 0x00010 -> mem_addr stays 0x00010/0x00012.
REQ-035 With ICACHE_REFILL_LASTBUF_EN: refill 0x00040, then miss 0x00040 again -> no mem_req, fetch one cycle after miss sampled, same write_data; miss 0x00044 -> full memory refill.
